// File: rtl/mips_cpu_reg_writeback.sv
// Register-file write-side driver: ALU results and load responses feed a small FIFO
// that drains one entry per cycle onto the register file write port.
// Latency: an entry accepted at edge k appears on the write port in cycle k..k+1 and commits at edge k+1.
// Backpressure: alu_ready drops while a load is offered, or when the FIFO is full and not draining.
// Loads cannot be stalled; they are dropped when the FIFO is full or the access is misaligned.
//
// Optional feature: define WB_V0_SHADOW_EN to add the register_v0 output (shadow of register 2).
//
// Ports:
//   clk, reset (async, active-low)
//   alu_valid/alu_ready/alu_dest/alu_data       ALU result handshake
//   mem_valid/mem_dest/mem_data/mem_size/
//   mem_unsigned/mem_addr_lo                    load response (no backpressure)
//   wb_stall                                    hold the FIFO head this cycle
//   writeEnable/writeAddress/dataIn             register file write port
//   query_a/query_b -> pend_a/pend_b, fwd_a/fwd_b   decode bypass lookup
//   busy, overflow_err, misalign_err            status / sticky errors
//   register_v0                                 (WB_V0_SHADOW_EN only) v0 shadow
module mips_cpu_reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_dest,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_dest,
  input  logic [31:0] mem_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [1:0]  mem_addr_lo,
  input  logic        wb_stall,
  output logic        writeEnable,
  output logic [4:0]  writeAddress,
  output logic [31:0] dataIn,
  input  logic [4:0]  query_a,
  input  logic [4:0]  query_b,
  output logic        pend_a,
  output logic        pend_b,
  output logic [31:0] fwd_a,
  output logic [31:0] fwd_b,
  output logic        busy,
  output logic        overflow_err,
  output logic        misalign_err
`ifdef WB_V0_SHADOW_EN
  ,
  output logic [31:0] register_v0
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    dest_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  logic [31:0] ld_data;
  logic        ld_misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_data     = '0;
    ld_misalign = 1'b0;
    ld_byte     = mem_data[{mem_addr_lo, 3'b000} +: 8];
    ld_half     = mem_addr_lo[1] ? mem_data[31:16] : mem_data[15:0];
    case (mem_size)
      2'b00: begin
        ld_data = {{24{ld_byte[7] & ~mem_unsigned}}, ld_byte};
      end
      2'b01: begin
        ld_misalign = mem_addr_lo[0];
        ld_data     = {{16{ld_half[15] & ~mem_unsigned}}, ld_half};
      end
      default: begin
        // size 11 behaves as a word access
        ld_misalign = (mem_addr_lo != 2'b00);
        ld_data     = mem_data;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake / FIFO control
  // ---------------------------------------------------------------------------
  logic        full;
  logic        pop;
  logic        room;
  logic        mem_take;
  logic        alu_take;
  logic        push;
  logic [4:0]  push_dest;
  logic [31:0] push_data;

  assign full = (count == CW'(DEPTH));
  assign busy = (count != '0);
  assign pop  = busy && !wb_stall;
  // Dequeue and enqueue share the cycle, so a draining full FIFO still has room.
  assign room = !full || pop;

  assign mem_take  = mem_valid && !ld_misalign && room;
  // reset gates alu_ready so no handshake completes while the block is held in reset.
  assign alu_ready = reset && !mem_valid && room;
  assign alu_take  = alu_valid && alu_ready;

  // Writes to register 0 complete their handshake but are never queued.
  assign push      = (mem_take && (mem_dest != 5'd0)) || (alu_take && (alu_dest != 5'd0));
  assign push_dest = mem_valid ? mem_dest : alu_dest;
  assign push_data = mem_valid ? ld_data  : alu_data;

  assign writeEnable  = pop;
  assign writeAddress = dest_q[rd_ptr];
  assign dataIn       = data_q[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (mem_valid && ld_misalign)          misalign_err <= 1'b1;
      if (mem_valid && !ld_misalign && !room) overflow_err <= 1'b1;
    end
  end

  // Payload storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      dest_q[wr_ptr] <= push_dest;
      data_q[wr_ptr] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Bypass lookup: walk entries oldest to youngest so the youngest match wins.
  // Entries pushed this cycle are not yet counted, hence invisible until next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin : bypass_scan
    logic [PW-1:0] idx;
    pend_a = 1'b0;
    pend_b = 1'b0;
    fwd_a  = '0;
    fwd_b  = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if ((query_a != 5'd0) && (dest_q[idx] == query_a)) begin
          pend_a = 1'b1;
          fwd_a  = data_q[idx];
        end
        if ((query_b != 5'd0) && (dest_q[idx] == query_b)) begin
          pend_b = 1'b1;
          fwd_b  = data_q[idx];
        end
      end
    end
  end

`ifdef WB_V0_SHADOW_EN
  // v0 shadow mirrors what the register file holds, including the write in flight.
  logic [31:0] v0_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v0_q <= '0;
    end else if (writeEnable && (writeAddress == 5'd2)) begin
      v0_q <= dataIn;
    end
  end

  assign register_v0 = (writeEnable && (writeAddress == 5'd2)) ? dataIn : v0_q;
`endif

endmodule

// File: tb/tb_mips_cpu_reg_writeback.sv
// Directed self-checking bench for mips_cpu_reg_writeback (DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked before the falling
// edge, and register-file writes are logged on the falling edge.
module tb_mips_cpu_reg_writeback;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_dest;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_dest;
  logic [31:0] mem_data;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [1:0]  mem_addr_lo;
  logic        wb_stall;
  logic        writeEnable;
  logic [4:0]  writeAddress;
  logic [31:0] dataIn;
  logic [4:0]  query_a;
  logic [4:0]  query_b;
  logic        pend_a;
  logic        pend_b;
  logic [31:0] fwd_a;
  logic [31:0] fwd_b;
  logic        busy;
  logic        overflow_err;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0]  wa_q [$];
  logic [31:0] wd_q [$];

  mips_cpu_reg_writeback #(.DEPTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_dest     (alu_dest),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_dest     (mem_dest),
    .mem_data     (mem_data),
    .mem_size     (mem_size),
    .mem_unsigned (mem_unsigned),
    .mem_addr_lo  (mem_addr_lo),
    .wb_stall     (wb_stall),
    .writeEnable  (writeEnable),
    .writeAddress (writeAddress),
    .dataIn       (dataIn),
    .query_a      (query_a),
    .query_b      (query_b),
    .pend_a       (pend_a),
    .pend_b       (pend_b),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .busy         (busy),
    .overflow_err (overflow_err),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every register file write; inputs are stable from here to the committing edge.
  always @(negedge clk) begin
    if (writeEnable === 1'b1) begin
      wa_q.push_back(writeAddress);
      wd_q.push_back(dataIn);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [4:0] a, input logic [31:0] d);
    logic [4:0]  oa;
    logic [31:0] od;
    oa = (idx < wa_q.size()) ? wa_q[idx] : 5'h1f;
    od = (idx < wd_q.size()) ? wd_q[idx] : 32'hxxxx_xxxx;
    chk({tag, "_addr"}, {27'd0, oa}, {27'd0, a});
    chk({tag, "_data"}, od, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic load(input logic [4:0] d, input logic [31:0] w, input logic [1:0] sz,
                      input logic uns, input logic [1:0] lo);
    mem_valid    = 1'b1;
    mem_dest     = d;
    mem_data     = w;
    mem_size     = sz;
    mem_unsigned = uns;
    mem_addr_lo  = lo;
  endtask

  initial begin
    reset = 1'b0; alu_valid = 1'b0; alu_dest = '0; alu_data = '0;
    mem_valid = 1'b0; mem_dest = '0; mem_data = '0; mem_size = '0;
    mem_unsigned = 1'b0; mem_addr_lo = '0; wb_stall = 1'b0;
    query_a = '0; query_b = '0;

    // Reset state
    #3;
    chk("rst_we",    {31'd0, writeEnable},  32'd0);
    chk("rst_busy",  {31'd0, busy},         32'd0);
    chk("rst_ready", {31'd0, alu_ready},    32'd0);
    chk("rst_pend",  {30'd0, pend_a, pend_b}, 32'd0);
    chk("rst_errs",  {30'd0, overflow_err, misalign_err}, 32'd0);
    #9 reset = 1'b1;
    tick();

    // 1. Single ALU write
    clear_log();
    alu_valid = 1'b1; alu_dest = 5'd5; alu_data = 32'h1234_5678;
    #1;
    chk("t1_ready", {31'd0, alu_ready}, 32'd1);
    chk("t1_we0",   {31'd0, writeEnable}, 32'd0);
    tick();
    alu_valid = 1'b0;
    #1;
    chk("t1_we1",   {31'd0, writeEnable}, 32'd1);
    chk("t1_addr",  {27'd0, writeAddress}, 32'd5);
    chk("t1_data",  dataIn, 32'h1234_5678);
    tick();
    chk("t1_busy",  {31'd0, busy}, 32'd0);
    chk("t1_nwr",   wa_q.size(), 32'd1);

    // 2. Load extraction
    clear_log();
    load(5'd3, 32'h80FF_7F01, 2'b00, 1'b0, 2'd1);
    tick();
    load(5'd4, 32'h80FF_7F01, 2'b00, 1'b0, 2'd3);
    #1;
    chk("t2_head", dataIn, 32'h0000_007F);
    tick();
    load(5'd6, 32'h80FF_7F01, 2'b01, 1'b1, 2'd2);
    tick();
    mem_valid = 1'b0;
    tick(); tick();
    chk("t2_nwr", wa_q.size(), 32'd3);
    chk_wr("t2_w0", 0, 5'd3, 32'h0000_007F);
    chk_wr("t2_w1", 1, 5'd4, 32'hFFFF_FF80);
    chk_wr("t2_w2", 2, 5'd6, 32'h0000_80FF);

    // 3. Load has priority over a simultaneous ALU result
    clear_log();
    load(5'd9, 32'hCAFE_BABE, 2'b10, 1'b0, 2'd0);
    alu_valid = 1'b1; alu_dest = 5'd10; alu_data = 32'h1111_1111;
    #1;
    chk("t3_ready0", {31'd0, alu_ready}, 32'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("t3_ready1", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    tick(); tick();
    chk("t3_nwr", wa_q.size(), 32'd2);
    chk_wr("t3_w0", 0, 5'd9,  32'hCAFE_BABE);
    chk_wr("t3_w1", 1, 5'd10, 32'h1111_1111);

    // 4. Fill under stall, overflowing load, then drain
    clear_log();
    wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_dest = 5'(11 + i); alu_data = 32'h100 + i;
      tick();
    end
    alu_dest = 5'd15; alu_data = 32'h999;
    #1;
    chk("t4_full_ready", {31'd0, alu_ready}, 32'd0);
    chk("t4_we_stall",   {31'd0, writeEnable}, 32'd0);
    alu_valid = 1'b0;
    load(5'd16, 32'h0000_DEAD, 2'b10, 1'b0, 2'd0);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("t4_ovf", {31'd0, overflow_err}, 32'd1);
    chk("t4_nowr", wa_q.size(), 32'd0);
    wb_stall = 1'b0;
    #1;
    chk("t4_drain_ready", {31'd0, alu_ready}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_nwr", wa_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk_wr("t4_w", i, 5'(11 + i), 32'h100 + i);

    // 5. Bypass, dest 0, misaligned half
    clear_log();
    wb_stall = 1'b1;
    query_a = 5'd8; query_b = 5'd0;
    alu_valid = 1'b1; alu_dest = 5'd8; alu_data = 32'hA;
    #1;
    chk("t5_push_invis", {31'd0, pend_a}, 32'd0);
    tick();
    alu_data = 32'hB;
    tick();
    alu_dest = 5'd0; alu_data = 32'h55;
    #1;
    chk("t5_pend_a", {31'd0, pend_a}, 32'd1);
    chk("t5_fwd_a",  fwd_a, 32'hB);
    chk("t5_pend_b", {31'd0, pend_b}, 32'd0);
    chk("t5_fwd_b",  fwd_b, 32'd0);
    chk("t5_r0_ready", {31'd0, alu_ready}, 32'd1);
    tick();
    alu_valid = 1'b0;
    wb_stall = 1'b0;
    tick(); tick(); tick();
    chk("t5_nwr", wa_q.size(), 32'd2);
    chk_wr("t5_w0", 0, 5'd8, 32'hA);
    chk_wr("t5_w1", 1, 5'd8, 32'hB);
    chk("t5_pend_gone", {31'd0, pend_a}, 32'd0);
    load(5'd7, 32'h1234_5678, 2'b01, 1'b0, 2'd1);
    tick();
    mem_valid = 1'b0;
    #1;
    chk("t5_misalign", {31'd0, misalign_err}, 32'd1);
    chk("t5_mis_busy", {31'd0, busy}, 32'd0);
    chk("t5_ovf_sticky", {31'd0, overflow_err}, 32'd1);

    // 6. Reset with queued entries
    clear_log();
    wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_dest = 5'(20 + i); alu_data = 32'h200 + i;
      tick();
    end
    alu_valid = 1'b0;
    wb_stall = 1'b0;
    #1;
    chk("t6_we_pre", {31'd0, writeEnable}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_we_rst",   {31'd0, writeEnable}, 32'd0);
    chk("t6_busy_rst", {31'd0, busy}, 32'd0);
    chk("t6_errs_rst", {30'd0, overflow_err, misalign_err}, 32'd0);
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("t6_nwr", wa_q.size(), 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
